// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: scanout reads always win, CPU pixel writes are buffered in a
// small FIFO and drain in idle cycles, and a clear sequencer fills the RAM with one colour.
module vram_port_arbiter #(
  parameter int unsigned COORD_W    = 8,
  parameter int unsigned COLOR_W    = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iWrValid,
  output logic                   oWrReady,
  input  logic [COORD_W-1:0]     iWrCol,
  input  logic [COORD_W-1:0]     iWrRow,
  input  logic [COLOR_W-1:0]     iWrColor,
  input  logic                   iRdReq,
  input  logic [2*COORD_W-1:0]   iRdAddr,
  output logic                   oRdValid,
  output logic [COLOR_W-1:0]     oRdData,
  input  logic                   iClearStart,
  input  logic [COLOR_W-1:0]     iClearColor,
  output logic                   oBusy,
  output logic                   oClearDone,
  output logic [2*COORD_W-1:0]   oMemAddr,
  output logic                   oMemWe,
  output logic [COLOR_W-1:0]     oMemWData,
  input  logic [COLOR_W-1:0]     iMemRData
);

  localparam int unsigned AddrW  = 2 * COORD_W;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = AddrW + 1;
  localparam int unsigned EntryW = AddrW + COLOR_W;

  typedef enum logic [1:0] {StIdle, StDrain, StClear} state_e;

  state_e state_q, state_d;

  logic [EntryW-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]      count_q, count_d;
  logic [CntW-1:0]    clr_cnt_q;
  logic [COLOR_W-1:0] clr_color_q;
  logic               rd_pend_q;
  logic               clr_last_q;

  logic               full, empty, push, pop, do_clear, clr_last;
  logic [EntryW-1:0]  head;

  assign full     = (count_q == (PtrW + 1)'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign push     = iWrValid && oWrReady;
  // Reads own the port; the clear sequencer outranks queued CPU writes.
  assign do_clear = !iRdReq && (state_q == StClear);
  assign pop      = !iRdReq && (state_q != StClear) && !empty;
  assign clr_last = do_clear && (clr_cnt_q == {1'b0, {AddrW{1'b1}}});
  assign head     = fifo_mem[rd_ptr_q];
  assign oRdData  = oRdValid ? iMemRData : '0;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (PtrW + 1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (iClearStart) state_d = StDrain;
      StDrain: if (count_d == '0) state_d = StClear;
      StClear: if (clr_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    oWrReady = 1'b0;
    oBusy    = 1'b0;
    unique case (state_q)
      StIdle:           oWrReady = !full;
      StDrain, StClear: oBusy    = 1'b1;
      default:          oBusy    = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {iWrRow, iWrCol, iWrColor};
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      clr_cnt_q   <= '0;
      clr_color_q <= '0;
      oMemAddr    <= '0;
      oMemWe      <= 1'b0;
      oMemWData   <= '0;
      rd_pend_q   <= 1'b0;
      oRdValid    <= 1'b0;
      clr_last_q  <= 1'b0;
      oClearDone  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;

      if (state_q == StIdle && iClearStart) begin
        clr_cnt_q   <= '0;
        clr_color_q <= iClearColor;
      end else if (do_clear) begin
        clr_cnt_q <= clr_cnt_q + CntW'(1);
      end

      if (iRdReq) begin
        oMemAddr <= iRdAddr;
        oMemWe   <= 1'b0;
      end else if (do_clear) begin
        oMemAddr  <= clr_cnt_q[AddrW-1:0];
        oMemWe    <= 1'b1;
        oMemWData <= clr_color_q;
      end else if (pop) begin
        oMemAddr  <= head[EntryW-1:COLOR_W];
        oMemWe    <= 1'b1;
        oMemWData <= head[COLOR_W-1:0];
      end else begin
        oMemWe <= 1'b0;
      end

      // RAM returns data one cycle after the address is presented.
      rd_pend_q  <= iRdReq;
      oRdValid   <= rd_pend_q;
      clr_last_q <= clr_last;
      oClearDone <= clr_last_q;
    end
  end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Randomised bench for vram_port_arbiter (COORD_W=2) against a queue/array reference model
// of the arbitration rules, with a behavioural synchronous RAM on the memory port.
module tb_vram_port_arbiter;

  localparam int unsigned CW    = 2;
  localparam int unsigned AW    = 2 * CW;
  localparam int unsigned NADDR = 1 << AW;
  localparam int unsigned DEPTH = 4;

  logic          clk, rst;
  logic          wr_valid, wr_ready;
  logic [CW-1:0] wr_col, wr_row;
  logic [2:0]    wr_color;
  logic          rd_req, rd_valid;
  logic [AW-1:0] rd_addr;
  logic [2:0]    rd_data;
  logic          clear_start, busy, clear_done;
  logic [2:0]    clear_color;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [2:0]    mem_wdata, mem_rdata;

  vram_port_arbiter #(.COORD_W(CW), .COLOR_W(3), .FIFO_DEPTH(DEPTH)) dut (
    .Clock      (clk),
    .Reset      (rst),
    .iWrValid   (wr_valid),
    .oWrReady   (wr_ready),
    .iWrCol     (wr_col),
    .iWrRow     (wr_row),
    .iWrColor   (wr_color),
    .iRdReq     (rd_req),
    .iRdAddr    (rd_addr),
    .oRdValid   (rd_valid),
    .oRdData    (rd_data),
    .iClearStart(clear_start),
    .iClearColor(clear_color),
    .oBusy      (busy),
    .oClearDone (clear_done),
    .oMemAddr   (mem_addr),
    .oMemWe     (mem_we),
    .oMemWData  (mem_wdata),
    .iMemRData  (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [2:0] ram [NADDR] = '{default: 3'd0};
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model: mode 0 idle, 1 draining, 2 clearing.
  logic [6:0]    m_q[$];
  logic [2:0]    m_ram [NADDR] = '{default: 3'd0};
  int            m_mode, m_clr;
  logic [2:0]    m_clr_color;
  logic          exp_we, exp_rd_valid, exp_done, rd_pend, done_pend;
  logic [AW-1:0] exp_addr;
  logic [2:0]    exp_wdata, exp_rd_data, rd_pend_data;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic m_ready();
    return (m_q.size() < DEPTH) && (m_mode == 0);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_mode = 0; m_clr = 0; m_clr_color = '0;
    exp_we = 0; exp_addr = '0; exp_wdata = '0; exp_rd_valid = 0; exp_rd_data = '0;
    exp_done = 0; rd_pend = 0; rd_pend_data = '0; done_pend = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int         mode_now;
    logic       push;
    logic [6:0] w;
    if (rst) begin
      model_reset();
      return;
    end
    mode_now     = m_mode;
    push         = wr_valid && m_ready();
    exp_rd_valid = rd_pend;
    exp_rd_data  = rd_pend_data;
    rd_pend      = rd_req;
    rd_pend_data = m_ram[rd_addr];
    exp_done     = done_pend;
    done_pend    = 0;
    if (rd_req) begin
      exp_addr = rd_addr;
      exp_we   = 0;
    end else if (mode_now == 2) begin
      exp_addr = AW'(m_clr);
      exp_we   = 1;
      exp_wdata = m_clr_color;
      m_ram[AW'(m_clr)] = m_clr_color;
      m_clr++;
      if (m_clr == int'(NADDR)) begin
        m_mode    = 0;
        done_pend = 1;
      end
    end else if (m_q.size() > 0) begin
      w = m_q.pop_front();
      exp_addr  = w[6:3];
      exp_we    = 1;
      exp_wdata = w[2:0];
      m_ram[w[6:3]] = w[2:0];
    end else begin
      exp_we = 0;
    end
    if (push) m_q.push_back({wr_row, wr_col, wr_color});
    if (mode_now == 0 && clear_start) begin
      m_mode = 1; m_clr = 0; m_clr_color = clear_color;
    end else if (mode_now == 1 && m_q.size() == 0) begin
      m_mode = 2;
    end
  endtask

  task automatic check_outputs();
    check_eq("wr_ready", 32'(wr_ready), 32'(m_ready()));
    check_eq("busy", 32'(busy), 32'(m_mode != 0));
    check_eq("mem_we", 32'(mem_we), 32'(exp_we));
    check_eq("mem_addr", 32'(mem_addr), 32'(exp_addr));
    if (exp_we) check_eq("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
    check_eq("rd_valid", 32'(rd_valid), 32'(exp_rd_valid));
    if (exp_rd_valid) check_eq("rd_data", 32'(rd_data), 32'(exp_rd_data));
    check_eq("clear_done", 32'(clear_done), 32'(exp_done));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  int   acc, pulses, wr7;
  logic injected, was_rst;

  initial begin
    rst = 1; wr_valid = 0; wr_col = '0; wr_row = '0; wr_color = '0;
    rd_req = 0; rd_addr = '0; clear_start = 0; clear_color = '0;
    model_reset();
    repeat (2) tick();
    rst = 0;
    tick();
    check_eq("post_reset_ready", 32'(wr_ready), 32'd1);

    // Single write: col=1,row=3 -> address 4'hD
    wr_valid = 1; wr_col = 2'd1; wr_row = 2'd3; wr_color = 3'b010;
    tick();
    wr_valid = 0;
    tick();
    check_eq("single_we", 32'(mem_we), 32'd1);
    check_eq("single_addr", 32'(mem_addr), 32'hD);
    check_eq("single_wdata", 32'(mem_wdata), 32'd2);

    // Back-to-back reads, second one returns the pixel just written
    rd_req = 1; rd_addr = 4'h6;
    tick();
    check_eq("rd_addr", 32'(mem_addr), 32'h6);
    rd_addr = 4'hD;
    tick();
    rd_req = 0;
    check_eq("rd_valid_n2", 32'(rd_valid), 32'd1);
    tick();
    check_eq("rd_stream_data", 32'(rd_data), 32'd2);
    tick();

    // Contention: writes offered while reads hold the port
    acc = 0; rd_req = 1; wr_valid = 1;
    for (int c = 0; c < 8; c++) begin
      rd_addr  = AW'($urandom);
      wr_col   = CW'(acc);
      wr_row   = CW'(acc + 1);
      wr_color = 3'(acc + 3);
      if (wr_ready) acc++;
      tick();
    end
    check_eq("accepted", 32'(acc), 32'd4);
    rd_req = 0; wr_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("order_we", 32'(mem_we), 32'd1);
      check_eq("order_addr", 32'(mem_addr), 32'(((i + 1) % 4) * 4 + i));
    end
    repeat (2) tick();

    // Clear with two writes queued behind reads
    rd_req = 1; wr_valid = 1;
    for (int i = 0; i < 2; i++) begin
      wr_col = CW'(i); wr_row = 2'd2; wr_color = 3'(i + 1);
      tick();
    end
    rd_req = 0; wr_valid = 0; clear_start = 1; clear_color = 3'd7;
    tick();
    clear_start = 0;
    pulses = 0; wr7 = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (clear_done) pulses++;
      if (mem_we && mem_wdata == 3'd7) wr7++;
    end
    check_eq("clear_writes", 32'(wr7), 32'd16);
    check_eq("clear_pulses", 32'(pulses), 32'd1);

    // Clear with a read at clr_cnt=5 and a reset at clr_cnt=9
    clear_start = 1; clear_color = 3'd5;
    tick();
    clear_start = 0; injected = 0; pulses = 0; was_rst = 0;
    for (int c = 0; c < 40; c++) begin
      rst    = (m_mode == 2 && m_clr == 9);
      rd_req = (m_mode == 2 && m_clr == 5 && !injected);
      if (rd_req) begin
        injected = 1;
        rd_addr  = AW'($urandom);
      end
      was_rst = rst;
      tick();
      if (clear_done) pulses++;
      if (was_rst) break;
    end
    rst = 0; rd_req = 0;
    check_eq("abort_reset_hit", 32'(was_rst), 32'd1);
    check_eq("abort_ready", 32'(wr_ready), 32'd1);
    check_eq("abort_busy", 32'(busy), 32'd0);
    repeat (4) begin
      tick();
      if (clear_done) pulses++;
    end
    check_eq("abort_no_done", 32'(pulses), 32'd0);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 299) == 0);
      rd_req      = ($urandom_range(0, 9) < 3);
      rd_addr     = AW'($urandom);
      wr_valid    = $urandom_range(0, 1) == 1;
      wr_col      = CW'($urandom);
      wr_row      = CW'($urandom);
      wr_color    = 3'($urandom);
      clear_start = ($urandom_range(0, 99) == 0);
      clear_color = 3'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
